aes_block_sequencer: RTL

Multi-block AES datapath sequencer between the HWPE streamer and the AES cipher core. It packs CHUNK_W-wide stream beats into BLOCK_W-wide blocks and drives the core with a start/done handshake. Results are unpacked back onto an output stream for a programmed number of blocks. It is the parametrised successor to the fixed 256-bit engine control: block width, chunk width and counter width are generic, and it adds a CTR mode with an internal counter block and keystream XOR.

---
 rtl/aes_package.sv | 28 ++
 rtl/aes_block_gearbox.sv | 60 ++++++
 rtl/aes_block_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/aes_package.sv
// rtl/aes_package.sv - shared AES sequencer types, default widths and counter helper
package aes_package;

  typedef enum logic {
    AES_ECB = 1'b0,
    AES_CTR = 1'b1
  } aes_mode_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GATHER     = 3'd1,
    CORE_START = 3'd2,
    CORE_WAIT  = 3'd3,
    EMIT       = 3'd4,
    FINISHED   = 3'd5
  } aes_seq_state_t;

  localparam int AES_SEQ_BLOCK_W = 128;
  localparam int AES_SEQ_CHUNK_W = 32;
  localparam int AES_SEQ_CNT_W   = 16;
  localparam int AES_SEQ_CTR_W   = 32;

  // CTR counter advances in its low word only and wraps without carrying upward
  function automatic logic [AES_SEQ_CTR_W-1:0] ctr_inc(input logic [AES_SEQ_CTR_W-1:0] v);
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/aes_block_gearbox.sv
// rtl/aes_block_gearbox.sv - beat counter with pack (beats->block) or unpack (block->beats) register
module aes_block_gearbox #(
  parameter int BLOCK_W = 128,
  parameter int CHUNK_W = 32,
  parameter int PACK    = 1,
  parameter int IN_W    = CHUNK_W,
  parameter int OUT_W   = BLOCK_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [IN_W-1:0]  data_i,
  output logic [OUT_W-1:0] data_o,
  output logic             last_o
);

  localparam int BEATS = BLOCK_W / CHUNK_W;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  logic [IDX_W-1:0]   r_idx;
  logic [BLOCK_W-1:0] r_block;

  assign last_o = (r_idx == LAST_IDX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx <= '0;
    end else if (load_i) begin
      r_idx <= '0;
    end else if (step_i) begin
      r_idx <= last_o ? '0 : r_idx + 1'b1;
    end
  end

  // Beat k always maps to block bits [k*CHUNK_W +: CHUNK_W] in both directions
  generate
    if (PACK != 0) begin : g_pack
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_block <= '0;
        end else if (step_i && !load_i) begin
          r_block[r_idx*CHUNK_W +: CHUNK_W] <= data_i;
        end
      end
      assign data_o = r_block;
    end else begin : g_unpack
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_block <= '0;
        end else if (load_i) begin
          r_block <= data_i;
        end
      end
      assign data_o = r_block[r_idx*CHUNK_W +: CHUNK_W];
    end
  endgenerate

endmodule

// File: rtl/aes_block_sequencer.sv
// rtl/aes_block_sequencer.sv - packs stream beats into AES blocks, drives the core, unpacks results
module aes_block_sequencer
  import aes_package::*;
#(
  parameter int BLOCK_W = AES_SEQ_BLOCK_W,
  parameter int CHUNK_W = AES_SEQ_CHUNK_W,
  parameter int CNT_W   = AES_SEQ_CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic [CNT_W-1:0]   num_blocks_i,
  input  logic [BLOCK_W-1:0] iv_i,
  input  logic [CHUNK_W-1:0] in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [BLOCK_W-1:0] core_block_o,
  output logic               core_start_o,
  input  logic [BLOCK_W-1:0] core_result_i,
  input  logic               core_done_i,
  output logic [CHUNK_W-1:0] out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   block_cnt_o
);

  localparam int CTR_W = AES_SEQ_CTR_W;

  aes_seq_state_t     r_state;
  aes_mode_t          r_mode;
  logic [CNT_W-1:0]   r_num_blocks;
  logic [CNT_W-1:0]   r_block_cnt;
  logic [BLOCK_W-1:0] r_ctr;
  logic               r_in_ready;
  logic               r_core_start;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_done;

  logic [BLOCK_W-1:0] w_in_block;
  logic [BLOCK_W-1:0] w_result;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_job_start;
  logic               w_in_fire;
  logic               w_in_last;
  logic               w_out_fire;
  logic               w_out_last;
  logic               w_core_fire;

  assign w_job_start = (r_state == IDLE) && start_i;
  assign w_in_fire   = r_in_ready && in_valid_i;
  assign w_out_fire  = r_out_valid && out_ready_i;
  assign w_core_fire = (r_state == CORE_WAIT) && core_done_i;
  assign w_cnt_next  = r_block_cnt + 1'b1;
  // In CTR the gathered plaintext stays in the pack register until the keystream returns
  assign w_result    = (r_mode == AES_CTR) ? (core_result_i ^ w_in_block) : core_result_i;

  aes_block_gearbox #(
    .BLOCK_W (BLOCK_W),
    .CHUNK_W (CHUNK_W),
    .PACK    (1),
    .IN_W    (CHUNK_W),
    .OUT_W   (BLOCK_W)
  ) u_pack (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (w_job_start),
    .step_i (w_in_fire),
    .data_i (in_data_i),
    .data_o (w_in_block),
    .last_o (w_in_last)
  );

  aes_block_gearbox #(
    .BLOCK_W (BLOCK_W),
    .CHUNK_W (CHUNK_W),
    .PACK    (0),
    .IN_W    (BLOCK_W),
    .OUT_W   (CHUNK_W)
  ) u_unpack (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (w_core_fire),
    .step_i (w_out_fire),
    .data_i (w_result),
    .data_o (out_data_o),
    .last_o (w_out_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_mode       <= AES_ECB;
      r_num_blocks <= '0;
      r_block_cnt  <= '0;
      r_ctr        <= '0;
      r_in_ready   <= 1'b0;
      r_core_start <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_mode       <= aes_mode_t'(mode_i);
            r_num_blocks <= num_blocks_i;
            r_ctr        <= iv_i;
            r_block_cnt  <= '0;
            r_busy       <= 1'b1;
            if (num_blocks_i == '0) begin
              r_state <= FINISHED;
              r_done  <= 1'b1;
            end else begin
              r_state    <= GATHER;
              r_in_ready <= 1'b1;
            end
          end
        end
        GATHER: begin
          if (w_in_fire && w_in_last) begin
            r_in_ready   <= 1'b0;
            r_core_start <= 1'b1;
            r_state      <= CORE_START;
          end
        end
        CORE_START: begin
          r_core_start <= 1'b0;
          r_state      <= CORE_WAIT;
        end
        CORE_WAIT: begin
          if (core_done_i) begin
            if (r_mode == AES_CTR) begin
              r_ctr <= {r_ctr[BLOCK_W-1:CTR_W], ctr_inc(r_ctr[CTR_W-1:0])};
            end
            r_out_valid <= 1'b1;
            r_state     <= EMIT;
          end
        end
        EMIT: begin
          if (w_out_fire && w_out_last) begin
            r_out_valid <= 1'b0;
            r_block_cnt <= w_cnt_next;
            if (w_cnt_next == r_num_blocks) begin
              r_state <= FINISHED;
              r_done  <= 1'b1;
            end else begin
              r_state    <= GATHER;
              r_in_ready <= 1'b1;
            end
          end
        end
        FINISHED: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready_o   = r_in_ready;
  assign core_start_o = r_core_start;
  assign core_block_o = (r_mode == AES_CTR) ? r_ctr : w_in_block;
  assign out_valid_o  = r_out_valid;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign block_cnt_o  = r_block_cnt;

endmodule
